// File: rtl/mips_pkg.sv
// Shared types and helpers for the MIPS data-side blocks.
//   dcache_state_t : data-cache controller FSM states
//   byte_lanes_t   : four memory byte lanes, lane [0] = bits 31:24 (big-endian)
//   word_to_lanes / lanes_to_word : conversion between a 32-bit word and lanes
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2
  } dcache_state_t;

  typedef logic [0:3][7:0] byte_lanes_t;

  function automatic byte_lanes_t word_to_lanes(input logic [31:0] word);
    byte_lanes_t lanes;
    lanes[0] = word[31:24];
    lanes[1] = word[23:16];
    lanes[2] = word[15:8];
    lanes[3] = word[7:0];
    return lanes;
  endfunction

  function automatic logic [31:0] lanes_to_word(input byte_lanes_t lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Storage for the direct-mapped data cache: one valid bit, tag and data word per line.
// Ports:
//   clk, rst_b         clock, asynchronous active-low reset (clears valid bits only)
//   rd_index           lookup index; rd_valid/rd_tag/rd_data are combinational reads
//   wr_en, wr_fill     write strobe; wr_fill also writes the tag and sets the valid bit
//   wr_index, wr_tag, wr_data   write address, tag and data
//   inv                clear every valid bit at the next edge; overrides a fill
module dcache_line_store #(
  parameter int NUM_LINES  = 16,
  parameter int INDEX_BITS = $clog2(NUM_LINES),
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data,
  input  logic                  inv
);

  logic [NUM_LINES-1:0] valid_r;
  logic [TAG_BITS-1:0]  tag_r  [NUM_LINES];
  logic [31:0]          data_r [NUM_LINES];

  assign rd_valid = valid_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_data  = data_r[rd_index];

  // Valid bits: invalidate wins over a fill landing on the same edge.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (inv) begin
      valid_r <= {NUM_LINES{1'b0}};
    end else if (wr_en && wr_fill) begin
      valid_r[wr_index] <= 1'b1;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Tag and data arrays carry no reset; a line is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r[wr_index] <= wr_data;
      if (wr_fill) begin
        tag_r[wr_index] <= wr_tag;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MIPS core.
// Ports:
//   clk, rst_b           clock, asynchronous active-low reset
//   core_addr/rd/wr/wdata  core load/store request (store wins over load)
//   core_rdata           load data, valid when core_rd && !stall
//   stall                hold the core; a request completes in its first stall==0 cycle
//   inv                  invalidate all lines
//   mem_addr             word-aligned memory address (latched request address)
//   mem_data_in          store bytes to memory, big-endian lanes
//   mem_data_out         load bytes from memory, big-endian lanes
//   mem_write_en         memory write strobe
//   hit_count/miss_count saturating statistics
module dcache_ctrl
  import mips_pkg::*;
#(
  parameter int NUM_LINES   = 16,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [31:0]          core_addr,
  input  logic                 core_rd,
  input  logic                 core_wr,
  input  logic [31:0]          core_wdata,
  output logic [31:0]          core_rdata,
  output logic                 stall,
  input  logic                 inv,
  output logic [31:0]          mem_addr,
  output byte_lanes_t          mem_data_in,
  input  byte_lanes_t          mem_data_out,
  output logic                 mem_write_en,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = 30 - INDEX_BITS;
  localparam int CW         = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0]        CNT_LOAD = CW'(MEM_LATENCY - 1);
  localparam logic [CW-1:0]        CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1'b1);
  localparam logic [CNT_WIDTH-1:0] STAT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] STAT_ONE = CNT_WIDTH'(1'b1);

  dcache_state_t          state_r, state_nxt_s;
  logic [CW-1:0]          cnt_r, cnt_nxt_s;
  logic [29:0]            addr_r;
  logic [31:0]            wdata_r;
  logic [CNT_WIDTH-1:0]   hit_count_r, miss_count_r;

  logic                   latch_s, hit_inc_s, miss_inc_s;
  logic                   st_wr_en_s, st_fill_s;
  logic [31:0]            st_wdata_s;
  logic                   stall_s, wen_s;
  logic [31:0]            rdata_s;

  logic [29:0]            look_addr_s;
  logic [INDEX_BITS-1:0]  look_index_s;
  logic [TAG_BITS-1:0]    look_tag_s;
  logic                   line_valid_s;
  logic [TAG_BITS-1:0]    line_tag_s;
  logic [31:0]            line_data_s;
  logic                   hit_s;

  // Byte offset never selects anything: the cache and memory are word-wide.
  logic                   addr_byte_unused_s;
  assign addr_byte_unused_s = ^core_addr[1:0];

  // Once a request is accepted the core may wiggle its address; look up the latched one.
  assign look_addr_s  = (state_r == IDLE) ? core_addr[31:2] : addr_r;
  assign look_index_s = look_addr_s[INDEX_BITS-1:0];
  assign look_tag_s   = look_addr_s[29:INDEX_BITS];
  assign hit_s        = line_valid_s && (line_tag_s == look_tag_s);

  dcache_line_store #(
    .NUM_LINES  (NUM_LINES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_store (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_index (look_index_s),
    .rd_valid (line_valid_s),
    .rd_tag   (line_tag_s),
    .rd_data  (line_data_s),
    .wr_en    (st_wr_en_s),
    .wr_fill  (st_fill_s),
    .wr_index (addr_r[INDEX_BITS-1:0]),
    .wr_tag   (addr_r[29:INDEX_BITS]),
    .wr_data  (st_wdata_s),
    .inv      (inv)
  );

  // Next-state, latency countdown, store writes and core-facing outputs.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    hit_inc_s   = 1'b0;
    miss_inc_s  = 1'b0;
    st_wr_en_s  = 1'b0;
    st_fill_s   = 1'b0;
    st_wdata_s  = wdata_r;
    stall_s     = 1'b0;
    wen_s       = 1'b0;
    rdata_s     = 32'h0000_0000;
    case (state_r)
      IDLE: begin
        if (core_wr) begin
          stall_s     = 1'b1;
          latch_s     = 1'b1;
          hit_inc_s   = hit_s;
          miss_inc_s  = !hit_s;
          cnt_nxt_s   = CNT_LOAD;
          state_nxt_s = WRITE_WAIT;
        end else if (core_rd) begin
          if (hit_s) begin
            rdata_s   = line_data_s;
            hit_inc_s = 1'b1;
          end else begin
            stall_s     = 1'b1;
            latch_s     = 1'b1;
            miss_inc_s  = 1'b1;
            cnt_nxt_s   = CNT_LOAD;
            state_nxt_s = READ_WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ_WAIT: begin
        if (cnt_r == CNT_ZERO) begin
          // Memory data bypasses straight to the core while the line is filled.
          rdata_s     = lanes_to_word(mem_data_out);
          st_wr_en_s  = 1'b1;
          st_fill_s   = 1'b1;
          st_wdata_s  = lanes_to_word(mem_data_out);
          state_nxt_s = IDLE;
        end else begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      WRITE_WAIT: begin
        wen_s = 1'b1;
        if (cnt_r == CNT_ZERO) begin
          // Write-through: refresh the cached copy only if the line still holds this address.
          st_wr_en_s  = hit_s;
          state_nxt_s = IDLE;
        end else begin
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, countdown and latched request.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      addr_r  <= 30'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (latch_s) begin
        addr_r  <= core_addr[31:2];
        wdata_r <= core_wdata;
      end
    end
  end

  // Saturating hit/miss statistics.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_count_r  <= {CNT_WIDTH{1'b0}};
      miss_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (hit_inc_s && (hit_count_r != STAT_MAX)) begin
        hit_count_r <= hit_count_r + STAT_ONE;
      end
      if (miss_inc_s && (miss_count_r != STAT_MAX)) begin
        miss_count_r <= miss_count_r + STAT_ONE;
      end
    end
  end

  assign core_rdata   = rdata_s;
  assign stall        = stall_s;
  assign mem_write_en = wen_s;
  assign mem_addr     = {addr_r, 2'b00};
  assign mem_data_in  = word_to_lanes(wdata_r);
  assign hit_count    = hit_count_r;
  assign miss_count   = miss_count_r;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios followed by randomized traffic,
// compared against a line-level cache model and a word-addressed memory model.
module tb_dcache_ctrl;
  import mips_pkg::*;

  localparam int NL  = 16;
  localparam int LAT = 4;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst_b;
  logic [31:0]   core_addr, core_wdata, core_rdata, mem_addr;
  logic          core_rd, core_wr, stall, inv, mem_write_en;
  byte_lanes_t   mem_data_in, mem_data_out;
  logic [CW-1:0] hit_count, miss_count;

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_LINES(NL), .MEM_LATENCY(LAT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_b(rst_b), .core_addr(core_addr), .core_rd(core_rd), .core_wr(core_wr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .stall(stall), .inv(inv),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per line plus backing memory.
  bit          m_valid [NL];
  logic [25:0] m_tag   [NL];
  logic [31:0] m_data  [NL];
  logic [31:0] mem_m   [logic [29:0]];
  int unsigned m_hits, m_misses;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return {wa[15:0] ^ 16'hC35A, ~wa[15:0]};
  endfunction

  function automatic void model_inv();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("hit_count", 64'(hit_count), 64'(m_hits));
    check("miss_count", 64'(miss_count), 64'(m_misses));
  endtask

  // Load; inv_cyc selects the request cycle (0..LAT) in which inv is pulsed, -1 for none.
  task automatic rd(input logic [31:0] a, input int inv_cyc);
    int idx;
    bit hit;
    logic [31:0] exp;
    idx = int'(a[5:2]);
    hit = m_valid[idx] && (m_tag[idx] == a[31:6]);
    exp = hit ? m_data[idx] : mem_word(a[31:2]);
    core_addr = a; core_rd = 1'b1; core_wr = 1'b0; inv = (inv_cyc == 0);
    mem_data_out = mem_word(a[31:2]);
    #1;
    if (hit) begin
      check("rd_hit_stall", 64'(stall), 64'd0);
      check("rd_hit_data", 64'(core_rdata), 64'(exp));
      m_hits++;
      if (inv_cyc == 0) model_inv();
      tick();
    end else begin
      check("rd_miss_stall", 64'(stall), 64'd1);
      m_misses++;
      if (inv_cyc == 0) model_inv();
      for (int k = 1; k < LAT; k++) begin
        tick();
        inv = (inv_cyc == k); core_addr = $urandom;
        #1;
        check("rd_wait_stall", 64'(stall), 64'd1);
        check("rd_wait_addr", 64'(mem_addr), 64'({a[31:2], 2'b00}));
        check("rd_wait_wen", 64'(mem_write_en), 64'd0);
        if (inv_cyc == k) model_inv();
      end
      tick();
      inv = (inv_cyc == LAT); core_addr = $urandom;
      #1;
      check("rd_done_stall", 64'(stall), 64'd0);
      check("rd_done_data", 64'(core_rdata), 64'(exp));
      if (inv_cyc == LAT) begin
        model_inv();
      end else begin
        m_valid[idx] = 1'b1; m_tag[idx] = a[31:6]; m_data[idx] = exp;
      end
      tick();
    end
    inv = 1'b0; core_rd = 1'b0;
    #1;
    check_counts();
  endtask

  // Store, optionally with core_rd also raised (store must win).
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    int idx;
    bit hit;
    idx = int'(a[5:2]);
    hit = m_valid[idx] && (m_tag[idx] == a[31:6]);
    core_addr = a; core_wdata = d; core_wr = 1'b1; core_rd = 1'($urandom_range(0, 1)); inv = 1'b0;
    #1;
    check("wr_req_stall", 64'(stall), 64'd1);
    check("wr_req_wen", 64'(mem_write_en), 64'd0);
    if (hit) m_hits++; else m_misses++;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      core_addr = $urandom; core_wdata = $urandom;
      #1;
      check("wr_wen", 64'(mem_write_en), 64'd1);
      check("wr_addr", 64'(mem_addr), 64'({a[31:2], 2'b00}));
      check("wr_data", 64'(mem_data_in), 64'(d));
      check("wr_lane0", 64'(mem_data_in[0]), 64'(d[31:24]));
      check("wr_lane3", 64'(mem_data_in[3]), 64'(d[7:0]));
      check("wr_stall", 64'(stall), (k < LAT) ? 64'd1 : 64'd0);
    end
    mem_m[a[31:2]] = d;
    if (hit) m_data[idx] = d;
    tick();
    core_wr = 1'b0; core_rd = 1'b0;
    #1;
    check("wr_after_wen", 64'(mem_write_en), 64'd0);
    check_counts();
  endtask

  task automatic idle_inv();
    core_rd = 1'b0; core_wr = 1'b0; inv = 1'b1;
    tick();
    inv = 1'b0;
    model_inv();
  endtask

  initial begin
    logic [31:0] a;
    int op;
    rst_b = 1'b0; core_addr = 32'h0; core_rd = 1'b0; core_wr = 1'b0; core_wdata = 32'h0;
    inv = 1'b0; mem_data_out = 32'h0;
    model_inv(); m_hits = 0; m_misses = 0;
    #1;
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_wen", 64'(mem_write_en), 64'd0);
    check("rst_rdata", 64'(core_rdata), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_data_in", 64'(mem_data_in), 64'd0);
    check_counts();
    tick();
    rst_b = 1'b1;
    tick();
    check("idle_stall", 64'(stall), 64'd0);

    // Fill then hit
    mem_m[30'h10] = 32'h1234_5678;
    rd(32'h0000_0040, -1);
    check("first_miss_count", 64'(miss_count), 64'd1);
    rd(32'h0000_0040, -1);
    check("first_hit_count", 64'(hit_count), 64'd1);
    // Conflict on index 0
    rd(32'h0000_0440, -1);
    rd(32'h0000_0040, -1);
    check("conflict_miss_count", 64'(miss_count), 64'd3);
    // Write-through hit, then no-allocate miss
    wr(32'h0000_0040, 32'hDEAD_BEEF);
    rd(32'h0000_0040, -1);
    check("wr_hit_count", 64'(hit_count), 64'd3);
    wr(32'h0000_0080, 32'hCAFE_F00D);
    rd(32'h0000_0080, -1);
    check("no_alloc_miss_count", 64'(miss_count), 64'd5);
    // Invalidate while idle, and on the fill-completion cycle
    idle_inv();
    rd(32'h0000_0040, -1);
    check("inv_miss_count", 64'(miss_count), 64'd6);
    idle_inv();
    rd(32'h0000_0040, LAT);
    rd(32'h0000_0040, -1);
    check("inv_fill_miss_count", 64'(miss_count), 64'd8);

    // Reset in the middle of a miss
    core_addr = 32'h0000_0100; core_rd = 1'b1; mem_data_out = mem_word(30'h40);
    tick();
    tick();
    rst_b = 1'b0; core_rd = 1'b0;
    #1;
    check("midrst_stall", 64'(stall), 64'd0);
    check("midrst_mem_addr", 64'(mem_addr), 64'd0);
    model_inv(); m_hits = 0; m_misses = 0;
    check_counts();
    tick();
    rst_b = 1'b1;
    tick();
    rd(32'h0000_0100, -1);
    check("midrst_rd_miss", 64'(miss_count), 64'd1);

    // Randomized traffic over a small address pool so hits and conflicts both occur
    for (int n = 0; n < 300; n++) begin
      a = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 19);
      if (op < 12) begin
        rd(a, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LAT)) : -1);
      end else if (op < 19) begin
        wr(a, $urandom);
      end else begin
        idle_inv();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
